// File: rtl/watchdog_pkg.sv
// Shared types for the multi-channel watchdog: channel state encoding and default width.
// Optional build macro used by this design: WATCHDOG_WINDOW_EN (adds the early-kick window check).
package watchdog_pkg;

  localparam int WDT_CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    WARN    = 2'd2,
    EXPIRED = 2'd3
  } wdt_state_e;

endpackage

// File: rtl/watchdog_timer_if.sv
// Control/status bundle between software (or bench) and the watchdog channels.
// WATCHDOG_WINDOW_EN adds the per-channel window_i threshold.
interface watchdog_timer_if
  import watchdog_pkg::*;
#(
  parameter int NUM_CH = 1,
  parameter int CNT_W  = WDT_CNT_W_DEFAULT
);

  // No valid/ready here: en_i is a level, kick_i/ack_i are one-cycle strobes taken on
  // every rising clk edge, and all status outputs are registered levels/pulses.
  logic [NUM_CH-1:0]       en_i;
  logic [NUM_CH-1:0]       kick_i;
  logic [NUM_CH-1:0]       ack_i;
  logic [NUM_CH-1:0]       mode_i;
  logic [NUM_CH*CNT_W-1:0] timeout_i;
  logic [NUM_CH*CNT_W-1:0] warn_thr_i;
`ifdef WATCHDOG_WINDOW_EN
  logic [NUM_CH*CNT_W-1:0] window_i;
`endif
  logic [NUM_CH*CNT_W-1:0] count_o;
  logic [NUM_CH-1:0]       warn_o;
  logic [NUM_CH-1:0]       expired_o;
  logic [NUM_CH-1:0]       early_kick_o;
  logic [2*NUM_CH-1:0]     dbg_state_o;

  modport master (
`ifdef WATCHDOG_WINDOW_EN
    output window_i,
`endif
    output en_i, kick_i, ack_i, mode_i, timeout_i, warn_thr_i,
    input  count_o, warn_o, expired_o, early_kick_o, dbg_state_o
  );

  modport slave (
`ifdef WATCHDOG_WINDOW_EN
    input  window_i,
`endif
    input  en_i, kick_i, ack_i, mode_i, timeout_i, warn_thr_i,
    output count_o, warn_o, expired_o, early_kick_o, dbg_state_o
  );

endinterface

// File: rtl/watchdog_channel.sv
// One watchdog channel: IDLE/RUN/WARN/EXPIRED FSM, saturating counter, thresholds latched on arm.
// WATCHDOG_WINDOW_EN adds a latched window; a kick below it is treated as an expiry.
module watchdog_channel
  import watchdog_pkg::*;
#(
  parameter int CNT_W = WDT_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             kick_i,
  input  logic             ack_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] timeout_i,
  input  logic [CNT_W-1:0] warn_thr_i,
`ifdef WATCHDOG_WINDOW_EN
  input  logic [CNT_W-1:0] window_i,
`endif
  output logic [CNT_W-1:0] count_o,
  output logic             warn_o,
  output logic             expired_o,
  output logic             early_kick_o,
  output wdt_state_e       state_o
);

  wdt_state_e       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic [CNT_W-1:0] warn_thr_q, warn_thr_d;
  logic             pulse_q, pulse_d;
  logic             early_q, early_d;
  logic             early_hit;

`ifdef WATCHDOG_WINDOW_EN
  logic [CNT_W-1:0] window_q, window_d;
  assign early_hit = (window_q != '0) && (count_q < window_q);
`else
  assign early_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    timeout_d  = timeout_q;
    warn_thr_d = warn_thr_q;
    pulse_d    = 1'b0;
    early_d    = early_q;
`ifdef WATCHDOG_WINDOW_EN
    window_d   = window_q;
`endif
    if (!en_i) begin
      state_d = IDLE;
      count_d = '0;
      early_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          timeout_d  = (timeout_i == '0) ? CNT_W'(1) : timeout_i;
          warn_thr_d = warn_thr_i;
`ifdef WATCHDOG_WINDOW_EN
          window_d   = window_i;
`endif
          count_d    = '0;
          state_d    = RUN;
        end
        RUN, WARN: begin
          if (kick_i) begin
            if (early_hit) begin
              state_d = EXPIRED;
              early_d = 1'b1;
            end else begin
              count_d = '0;
              state_d = RUN;
            end
          end else if (count_q >= timeout_q) begin
            if (mode_i) begin
              count_d = '0;
              pulse_d = 1'b1;
              state_d = RUN;
            end else begin
              state_d = EXPIRED;
            end
          end else begin
            count_d = count_q + CNT_W'(1);
            state_d = RUN;
          end
        end
        EXPIRED: begin
          if (ack_i) begin
            state_d = RUN;
            count_d = '0;
            early_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
      // WARN tracks the next count so warn_o lines up with count_o in the same cycle.
      if ((state_d == RUN) && (warn_thr_d < timeout_d) && (count_d >= warn_thr_d)) begin
        state_d = WARN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      timeout_q  <= '0;
      warn_thr_q <= '0;
      pulse_q    <= 1'b0;
      early_q    <= 1'b0;
`ifdef WATCHDOG_WINDOW_EN
      window_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      timeout_q  <= timeout_d;
      warn_thr_q <= warn_thr_d;
      pulse_q    <= pulse_d;
      early_q    <= early_d;
`ifdef WATCHDOG_WINDOW_EN
      window_q   <= window_d;
`endif
    end
  end

  assign count_o      = count_q;
  assign warn_o       = (state_q == WARN);
  assign expired_o    = (state_q == EXPIRED) || pulse_q;
  assign early_kick_o = early_q;
  assign state_o      = state_q;

endmodule

// File: rtl/watchdog_timer.sv
// Multi-channel watchdog top: NUM_CH independent channels plus a registered, masked halt request.
// WATCHDOG_WINDOW_EN enables the early-kick window on every channel.
module watchdog_timer
  import watchdog_pkg::*;
#(
  parameter int               NUM_CH   = 1,
  parameter int               CNT_W    = WDT_CNT_W_DEFAULT,
  parameter logic [NUM_CH-1:0] HALT_MSK = '1
) (
  input  logic              clk,
  input  logic              rst,
  watchdog_timer_if.slave   bus,
  output logic              halt_req_o
);

  logic [NUM_CH*CNT_W-1:0] count_w;
  logic [NUM_CH-1:0]       warn_w;
  logic [NUM_CH-1:0]       expired_w;
  logic [NUM_CH-1:0]       early_w;
  wdt_state_e              state_w [NUM_CH];
  logic [2*NUM_CH-1:0]     dbg_w;
  logic                    halt_q, halt_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    watchdog_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .en_i         (bus.en_i[g]),
      .kick_i       (bus.kick_i[g]),
      .ack_i        (bus.ack_i[g]),
      .mode_i       (bus.mode_i[g]),
      .timeout_i    (bus.timeout_i[g*CNT_W +: CNT_W]),
      .warn_thr_i   (bus.warn_thr_i[g*CNT_W +: CNT_W]),
`ifdef WATCHDOG_WINDOW_EN
      .window_i     (bus.window_i[g*CNT_W +: CNT_W]),
`endif
      .count_o      (count_w[g*CNT_W +: CNT_W]),
      .warn_o       (warn_w[g]),
      .expired_o    (expired_w[g]),
      .early_kick_o (early_w[g]),
      .state_o      (state_w[g])
    );
  end

  always_comb begin
    dbg_w = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      dbg_w[2*i +: 2] = state_w[i];
    end
  end

  // Extra register stage so the halt path is glitch-free for a clock-gate enable.
  assign halt_d = |(expired_w & HALT_MSK);

  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end

  assign bus.count_o      = count_w;
  assign bus.warn_o       = warn_w;
  assign bus.expired_o    = expired_w;
  assign bus.early_kick_o = early_w;
  assign bus.dbg_state_o  = dbg_w;
  assign halt_req_o       = halt_q;

endmodule
